// File: rtl/data_mem_ctrl.sv
// Single-port data memory access controller: round-robin arbitration between core and
// loader, one-cycle read return, and a hardware sequencer that zeroes every location.
module data_mem_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clr_start_i,
  output logic              clr_busy_o,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  output logic              core_gnt_o,
  output logic              core_rvalid_o,
  output logic [DATA_W-1:0] core_rdata_o,
  input  logic              ldr_req_i,
  input  logic              ldr_we_i,
  input  logic [ADDR_W-1:0] ldr_addr_i,
  input  logic [DATA_W-1:0] ldr_wdata_i,
  output logic              ldr_gnt_o,
  output logic              ldr_rvalid_o,
  output logic [DATA_W-1:0] ldr_rdata_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic {CLEAR, IDLE} state_e;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_LDR  = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] clrCnt_q;
  logic              rrLast_q;
  logic              rdPend_q;
  logic              rdOwner_q;
  logic [DATA_W-1:0] coreHold_q;
  logic [DATA_W-1:0] ldrHold_q;
  logic              coreGnt;
  logic              ldrGnt;
  logic              rdPend_d;

  // Grant and memory port mux are combinational; a pending clr_start blocks grants
  // so the clear never races a fresh access.
  always_comb begin
    coreGnt     = 1'b0;
    ldrGnt      = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (!reset_i) begin
      if (state_q == CLEAR) begin
        mem_we_o   = 1'b1;
        mem_addr_o = clrCnt_q;
      end else if (!clr_start_i) begin
        if (core_req_i && (!ldr_req_i || rrLast_q == OWN_LDR)) begin
          coreGnt = 1'b1;
        end else if (ldr_req_i) begin
          ldrGnt = 1'b1;
        end
        if (coreGnt) begin
          mem_we_o    = core_we_i;
          mem_addr_o  = core_addr_i;
          mem_wdata_o = core_wdata_i;
        end else if (ldrGnt) begin
          mem_we_o    = ldr_we_i;
          mem_addr_o  = ldr_addr_i;
          mem_wdata_o = ldr_wdata_i;
        end
      end
    end
  end

  assign rdPend_d      = (coreGnt && !core_we_i) || (ldrGnt && !ldr_we_i);
  assign core_gnt_o    = coreGnt;
  assign ldr_gnt_o     = ldrGnt;
  assign clr_busy_o    = reset_i || (state_q == CLEAR);
  assign core_rvalid_o = !reset_i && rdPend_q && (rdOwner_q == OWN_CORE);
  assign ldr_rvalid_o  = !reset_i && rdPend_q && (rdOwner_q == OWN_LDR);
  assign core_rdata_o  = core_rvalid_o ? mem_rdata_i : coreHold_q;
  assign ldr_rdata_o   = ldr_rvalid_o  ? mem_rdata_i : ldrHold_q;

  // Read data is returned straight from memory; each requester keeps its last value
  // while the other one owns the return slot.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= CLEAR;
      clrCnt_q   <= '0;
      rrLast_q   <= OWN_LDR;
      rdPend_q   <= 1'b0;
      rdOwner_q  <= OWN_CORE;
      coreHold_q <= '0;
      ldrHold_q  <= '0;
    end else begin
      rdPend_q <= rdPend_d;
      if (core_rvalid_o) coreHold_q <= mem_rdata_i;
      if (ldr_rvalid_o)  ldrHold_q  <= mem_rdata_i;
      if (coreGnt) begin
        rrLast_q  <= OWN_CORE;
        rdOwner_q <= OWN_CORE;
      end else if (ldrGnt) begin
        rrLast_q  <= OWN_LDR;
        rdOwner_q <= OWN_LDR;
      end
      case (state_q)
        CLEAR: begin
          clrCnt_q <= clrCnt_q + ADDR_W'(1);
          if (clrCnt_q == LAST_ADDR) state_q <= IDLE;
        end
        IDLE: begin
          if (clr_start_i) begin
            state_q  <= CLEAR;
            clrCnt_q <= '0;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl with a 16x8 memory model attached
// to the memory port (one-cycle registered read).
module tb_data_mem_ctrl;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       clr_start_i = 1'b0;
  logic       clr_busy_o;
  logic       core_req_i = 1'b0, core_we_i = 1'b0;
  logic [3:0] core_addr_i = '0;
  logic [7:0] core_wdata_i = '0;
  logic       core_gnt_o, core_rvalid_o;
  logic [7:0] core_rdata_o;
  logic       ldr_req_i = 1'b0, ldr_we_i = 1'b0;
  logic [3:0] ldr_addr_i = '0;
  logic [7:0] ldr_wdata_i = '0;
  logic       ldr_gnt_o, ldr_rvalid_o;
  logic [7:0] ldr_rdata_o;
  logic       mem_we_o;
  logic [3:0] mem_addr_o;
  logic [7:0] mem_wdata_o;
  logic [7:0] memRdata = '0;
  logic [7:0] memModel [16];

  int passCount = 0;
  int checkCount = 0;

  data_mem_ctrl #(.ADDR_W(4), .DATA_W(8), .DEPTH(16)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .clr_start_i(clr_start_i), .clr_busy_o(clr_busy_o),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_addr_i(core_addr_i),
    .core_wdata_i(core_wdata_i), .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o),
    .core_rdata_o(core_rdata_o), .ldr_req_i(ldr_req_i), .ldr_we_i(ldr_we_i),
    .ldr_addr_i(ldr_addr_i), .ldr_wdata_i(ldr_wdata_i), .ldr_gnt_o(ldr_gnt_o),
    .ldr_rvalid_o(ldr_rvalid_o), .ldr_rdata_o(ldr_rdata_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(memRdata)
  );

  always #5 clk_i = ~clk_i;

  // Memory starts full of 0xFF so that only a real clear produces zeros.
  initial begin
    for (int i = 0; i < 16; i++) memModel[i] = 8'hFF;
  end

  always @(posedge clk_i) begin
    if (mem_we_o) memModel[mem_addr_o] <= mem_wdata_o;
    memRdata <= memModel[mem_addr_o];
  end

  // Inputs change just after the falling edge; outputs are sampled 2 time units later.
  task automatic drive(input logic rst, input logic clr,
                       input logic cReq, input logic cWe, input logic [3:0] cAddr, input logic [7:0] cData,
                       input logic lReq, input logic lWe, input logic [3:0] lAddr, input logic [7:0] lData);
    @(negedge clk_i);
    reset_i = rst; clr_start_i = clr;
    core_req_i = cReq; core_we_i = cWe; core_addr_i = cAddr; core_wdata_i = cData;
    ldr_req_i = lReq; ldr_we_i = lWe; ldr_addr_i = lAddr; ldr_wdata_i = lData;
    #2;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1, 0, 0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
      checkCount++;
      if ({clr_busy_o, core_gnt_o, ldr_gnt_o, core_rvalid_o, ldr_rvalid_o, mem_we_o, mem_addr_o, mem_wdata_o}
          !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00})
        $display("[TB] FAIL reset_outputs cycle %0d: busy=%b gnt=%b%b rv=%b%b we=%b addr=%h wd=%h, expected busy=1 rest 0",
                 c, clr_busy_o, core_gnt_o, ldr_gnt_o, core_rvalid_o, ldr_rvalid_o, mem_we_o, mem_addr_o, mem_wdata_o);
      else passCount++;
    end
    for (int k = 0; k < 16; k++) begin
      drive(0, 0, 0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
      checkCount++;
      if ({clr_busy_o, mem_we_o, mem_addr_o, mem_wdata_o} !== {1'b1, 1'b1, 4'(k), 8'h00})
        $display("[TB] FAIL clear_walk k=%0d: busy=%b we=%b addr=%h wd=%h, expected 1 1 %h 00",
                 k, clr_busy_o, mem_we_o, mem_addr_o, mem_wdata_o, 4'(k));
      else passCount++;
    end
    drive(0, 0, 0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
    checkCount++;
    if ({clr_busy_o, mem_we_o} !== 2'b00)
      $display("[TB] FAIL clear_done: busy=%b we=%b, expected 0 0", clr_busy_o, mem_we_o);
    else passCount++;
    drive(0, 0, 1, 0, 4'd15, 8'h00, 0, 0, 4'd0, 8'h00);
    checkCount++;
    if ({core_gnt_o, mem_we_o, mem_addr_o} !== {1'b1, 1'b0, 4'hF})
      $display("[TB] FAIL read15_grant: gnt=%b we=%b addr=%h, expected 1 0 f", core_gnt_o, mem_we_o, mem_addr_o);
    else passCount++;
    drive(0, 0, 1, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
    checkCount++;
    if ({core_gnt_o, core_rvalid_o, core_rdata_o} !== {1'b1, 1'b1, 8'h00})
      $display("[TB] FAIL read15_return: gnt=%b rv=%b rdata=%h, expected 1 1 00", core_gnt_o, core_rvalid_o, core_rdata_o);
    else passCount++;
    drive(0, 0, 0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
    checkCount++;
    if ({core_rvalid_o, core_rdata_o, ldr_rvalid_o} !== {1'b1, 8'h00, 1'b0})
      $display("[TB] FAIL read0_return: rv=%b rdata=%h ldr_rv=%b, expected 1 00 0", core_rvalid_o, core_rdata_o, ldr_rvalid_o);
    else passCount++;
  endtask

  task automatic test_write_read();
    drive(0, 0, 1, 1, 4'd3, 8'hA5, 0, 0, 4'd0, 8'h00);
    checkCount++;
    if ({core_gnt_o, mem_we_o, mem_addr_o, mem_wdata_o} !== {1'b1, 1'b1, 4'h3, 8'hA5})
      $display("[TB] FAIL write3: gnt=%b we=%b addr=%h wd=%h, expected 1 1 3 a5", core_gnt_o, mem_we_o, mem_addr_o, mem_wdata_o);
    else passCount++;
    drive(0, 0, 1, 0, 4'd3, 8'h00, 0, 0, 4'd0, 8'h00);
    checkCount++;
    if ({core_gnt_o, mem_we_o, core_rvalid_o} !== 3'b100)
      $display("[TB] FAIL read3_grant: gnt=%b we=%b rv=%b, expected 1 0 0", core_gnt_o, mem_we_o, core_rvalid_o);
    else passCount++;
    drive(0, 0, 0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
    checkCount++;
    if ({core_rvalid_o, core_rdata_o, ldr_rvalid_o} !== {1'b1, 8'hA5, 1'b0})
      $display("[TB] FAIL read3_return: rv=%b rdata=%h ldr_rv=%b, expected 1 a5 0", core_rvalid_o, core_rdata_o, ldr_rvalid_o);
    else passCount++;
  endtask

  task automatic test_back_to_back();
    drive(0, 0, 1, 1, 4'd1, 8'h11, 0, 0, 4'd0, 8'h00);
    checkCount++;
    if (core_gnt_o !== 1'b1) $display("[TB] FAIL preload1: gnt=%b, expected 1", core_gnt_o);
    else passCount++;
    // Loader write last leaves the core as tie-break winner for the alternating run.
    drive(0, 0, 0, 0, 4'd0, 8'h00, 1, 1, 4'd2, 8'h22);
    checkCount++;
    if ({ldr_gnt_o, mem_addr_o, mem_wdata_o} !== {1'b1, 4'h2, 8'h22})
      $display("[TB] FAIL preload2: gnt=%b addr=%h wd=%h, expected 1 2 22", ldr_gnt_o, mem_addr_o, mem_wdata_o);
    else passCount++;
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 1, 0, 4'd1, 8'h00, 1, 0, 4'd2, 8'h00);
      checkCount++;
      if ({core_gnt_o, ldr_gnt_o} !== {(i % 2 == 0), (i % 2 == 1)})
        $display("[TB] FAIL rr_grant i=%0d: gnt core/ldr=%b%b, expected %b%b", i, core_gnt_o, ldr_gnt_o, (i % 2 == 0), (i % 2 == 1));
      else passCount++;
      if (i >= 1) begin
        checkCount++;
        if (i % 2 == 1) begin
          if ({core_rvalid_o, ldr_rvalid_o, core_rdata_o} !== {1'b1, 1'b0, 8'h11})
            $display("[TB] FAIL rr_core_return i=%0d: rv=%b%b rdata=%h, expected 10 11", i, core_rvalid_o, ldr_rvalid_o, core_rdata_o);
          else passCount++;
        end else begin
          if ({core_rvalid_o, ldr_rvalid_o, ldr_rdata_o, core_rdata_o} !== {1'b0, 1'b1, 8'h22, 8'h11})
            $display("[TB] FAIL rr_ldr_return i=%0d: rv=%b%b ldr_rdata=%h core_rdata=%h, expected 01 22 11",
                     i, core_rvalid_o, ldr_rvalid_o, ldr_rdata_o, core_rdata_o);
          else passCount++;
        end
      end
      if (i >= 3 && i % 2 == 1) begin
        checkCount++;
        if (ldr_rdata_o !== 8'h22)
          $display("[TB] FAIL rr_ldr_hold i=%0d: ldr_rdata=%h, expected 22", i, ldr_rdata_o);
        else passCount++;
      end
    end
    drive(0, 0, 0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
    checkCount++;
    if ({core_rvalid_o, ldr_rvalid_o, ldr_rdata_o} !== {1'b0, 1'b1, 8'h22})
      $display("[TB] FAIL rr_last_return: rv=%b%b ldr_rdata=%h, expected 01 22", core_rvalid_o, ldr_rvalid_o, ldr_rdata_o);
    else passCount++;
  endtask

  task automatic test_clr_start();
    drive(0, 0, 1, 1, 4'd7, 8'h5C, 0, 0, 4'd0, 8'h00);
    checkCount++;
    if (core_gnt_o !== 1'b1) $display("[TB] FAIL preload7: gnt=%b, expected 1", core_gnt_o);
    else passCount++;
    drive(0, 0, 1, 0, 4'd7, 8'h00, 0, 0, 4'd0, 8'h00);
    checkCount++;
    if (core_gnt_o !== 1'b1) $display("[TB] FAIL read7_grant: gnt=%b, expected 1", core_gnt_o);
    else passCount++;
    drive(0, 1, 1, 0, 4'd7, 8'h00, 1, 0, 4'd7, 8'h00);
    checkCount++;
    if ({core_gnt_o, ldr_gnt_o, mem_we_o, mem_addr_o, core_rvalid_o, core_rdata_o}
        !== {1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 8'h5C})
      $display("[TB] FAIL clr_start_cycle: gnt=%b%b we=%b addr=%h rv=%b rdata=%h, expected 00 0 0 1 5c",
               core_gnt_o, ldr_gnt_o, mem_we_o, mem_addr_o, core_rvalid_o, core_rdata_o);
    else passCount++;
    for (int k = 0; k < 16; k++) begin
      drive(0, 0, 1, 0, 4'd7, 8'h00, 1, 0, 4'd7, 8'h00);
      checkCount++;
      if ({clr_busy_o, core_gnt_o, ldr_gnt_o, mem_we_o, mem_addr_o, mem_wdata_o}
          !== {1'b1, 1'b0, 1'b0, 1'b1, 4'(k), 8'h00})
        $display("[TB] FAIL cmd_clear k=%0d: busy=%b gnt=%b%b we=%b addr=%h wd=%h, expected 1 00 1 %h 00",
                 k, clr_busy_o, core_gnt_o, ldr_gnt_o, mem_we_o, mem_addr_o, mem_wdata_o, 4'(k));
      else passCount++;
    end
    drive(0, 0, 1, 0, 4'd7, 8'h00, 1, 0, 4'd7, 8'h00);
    checkCount++;
    if ({clr_busy_o, core_gnt_o, ldr_gnt_o} !== 3'b001)
      $display("[TB] FAIL post_clear_grant: busy=%b gnt=%b%b, expected 0 01", clr_busy_o, core_gnt_o, ldr_gnt_o);
    else passCount++;
    drive(0, 0, 1, 0, 4'd7, 8'h00, 0, 0, 4'd0, 8'h00);
    checkCount++;
    if ({core_gnt_o, ldr_rvalid_o, ldr_rdata_o} !== {1'b1, 1'b1, 8'h00})
      $display("[TB] FAIL ldr_read7: core_gnt=%b ldr_rv=%b ldr_rdata=%h, expected 1 1 00", core_gnt_o, ldr_rvalid_o, ldr_rdata_o);
    else passCount++;
    drive(0, 0, 0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
    checkCount++;
    if ({core_rvalid_o, core_rdata_o} !== {1'b1, 8'h00})
      $display("[TB] FAIL core_read7: rv=%b rdata=%h, expected 1 00", core_rvalid_o, core_rdata_o);
    else passCount++;
  endtask

  task automatic test_reset_mid();
    drive(0, 0, 1, 0, 4'd3, 8'h00, 0, 0, 4'd0, 8'h00);
    checkCount++;
    if (core_gnt_o !== 1'b1) $display("[TB] FAIL pend_read_grant: gnt=%b, expected 1", core_gnt_o);
    else passCount++;
    drive(1, 0, 0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
    checkCount++;
    if ({clr_busy_o, core_rvalid_o, ldr_rvalid_o, mem_we_o} !== 4'b1000)
      $display("[TB] FAIL reset_pending: busy=%b rv=%b%b we=%b, expected 1 00 0", clr_busy_o, core_rvalid_o, ldr_rvalid_o, mem_we_o);
    else passCount++;
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 1, 1, 4'd9, 8'h3C, 0, 0, 4'd0, 8'h00);
      checkCount++;
      if ({core_gnt_o, core_rvalid_o, mem_we_o, mem_addr_o} !== {1'b0, 1'b0, 1'b1, 4'(k)})
        $display("[TB] FAIL partial_clear k=%0d: gnt=%b rv=%b we=%b addr=%h, expected 0 0 1 %h",
                 k, core_gnt_o, core_rvalid_o, mem_we_o, mem_addr_o, 4'(k));
      else passCount++;
    end
    drive(1, 0, 1, 1, 4'd9, 8'h3C, 0, 0, 4'd0, 8'h00);
    checkCount++;
    if ({clr_busy_o, core_gnt_o, mem_we_o} !== 3'b100)
      $display("[TB] FAIL reset_mid_clear: busy=%b gnt=%b we=%b, expected 1 0 0", clr_busy_o, core_gnt_o, mem_we_o);
    else passCount++;
    for (int k = 0; k < 16; k++) begin
      drive(0, 0, 1, 1, 4'd9, 8'h3C, 0, 0, 4'd0, 8'h00);
      checkCount++;
      if ({clr_busy_o, core_gnt_o, mem_we_o, mem_addr_o, mem_wdata_o} !== {1'b1, 1'b0, 1'b1, 4'(k), 8'h00})
        $display("[TB] FAIL restart_clear k=%0d: busy=%b gnt=%b we=%b addr=%h wd=%h, expected 1 0 1 %h 00",
                 k, clr_busy_o, core_gnt_o, mem_we_o, mem_addr_o, mem_wdata_o, 4'(k));
      else passCount++;
    end
    drive(0, 0, 1, 1, 4'd9, 8'h3C, 0, 0, 4'd0, 8'h00);
    checkCount++;
    if ({clr_busy_o, core_gnt_o, mem_we_o, mem_addr_o, mem_wdata_o} !== {1'b0, 1'b1, 1'b1, 4'h9, 8'h3C})
      $display("[TB] FAIL first_idle_grant: busy=%b gnt=%b we=%b addr=%h wd=%h, expected 0 1 1 9 3c",
               clr_busy_o, core_gnt_o, mem_we_o, mem_addr_o, mem_wdata_o);
    else passCount++;
    drive(0, 0, 1, 0, 4'd9, 8'h00, 0, 0, 4'd0, 8'h00);
    drive(0, 0, 0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
    checkCount++;
    if ({core_rvalid_o, core_rdata_o} !== {1'b1, 8'h3C})
      $display("[TB] FAIL read9_return: rv=%b rdata=%h, expected 1 3c", core_rvalid_o, core_rdata_o);
    else passCount++;
  endtask

  initial begin
    $display("[TB] data_mem_ctrl directed tests starting");
    test_reset();
    test_write_read();
    test_back_to_back();
    test_clr_start();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
